exc_seq: RTL and testbench

Exception/interrupt entry and exit sequencer for the multicycle MIPS core. Sits between the control unit and `cp0`. At an instruction boundary it takes a pending `intreq` by writing EPC, setting EXL and redirecting fetch to the handler. On a retiring ERET it clears EXL and redirects fetch to EPC. It owns every `cp0` write strobe during these sequences and stalls fetch while they run.

---
 rtl/exc_pkg.sv | 19 +
 rtl/exc_stat_cnt.sv | 24 ++
 rtl/exc_seq.sv | 110 +++++++++++
 tb/tb_exc_seq.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/exc_pkg.sv
// Shared definitions for the exception/interrupt sequencer: FSM encoding,
// cp0 register select codes and the default handler entry point.
package exc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SAVE   = 2'd1,
        ST_ENTER  = 2'd2,
        ST_RETURN = 2'd3
    } exc_state_t;

    localparam logic [4:0] SEL_SR    = 5'd12;
    localparam logic [4:0] SEL_CAUSE = 5'd13;
    localparam logic [4:0] SEL_EPC   = 5'd14;
    localparam logic [4:0] SEL_PRID  = 5'd15;

    localparam logic [31:0] DEFAULT_HANDLER_ADDR = 32'h0000_4180;

endpackage

// File: rtl/exc_stat_cnt.sv
// Saturating event counter with increment and synchronous clear.
module exc_stat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != {W{1'b1}})) begin
            count_reg <= count_reg + 1'b1;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/exc_seq.sv
// Exception/interrupt entry and ERET exit sequencer between control and cp0.
// Optional accepted-interrupt counter is built when EXC_SEQ_STATS_EN is defined.
module exc_seq
    import exc_pkg::*;
#(
    parameter logic [31:0] HANDLER_ADDR = DEFAULT_HANDLER_ADDR,
    parameter int          CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             intreq,
    input  logic             instr_done,
    input  logic             eret,
    input  logic [31:0]      next_pc,
    input  logic [31:0]      epc,
    output logic [31:0]      cp0_pc,
    output logic             cp0_wen,
    output logic [4:0]       cp0_sel,
    output logic             exlset,
    output logic             exlclr,
    output logic             pc_redirect,
    output logic [31:0]      redirect_pc,
    output logic             stall,
    output logic [CNT_W-1:0] int_count
);

    exc_state_t  state_reg, state_next;
    logic [31:0] cp0_pc_reg;
    logic [31:0] redirect_pc_reg;
    logic [4:0]  cp0_sel_reg;
    logic        cp0_wen_reg;
    logic        exlset_reg;
    logic        exlclr_reg;
    logic        pc_redirect_reg;
    logic        stall_reg;

    // ERET wins over a simultaneous interrupt; other states always fall through.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (instr_done && eret) begin
                    state_next = ST_RETURN;
                end else if (instr_done && intreq) begin
                    state_next = ST_SAVE;
                end
            end
            ST_SAVE:   state_next = ST_ENTER;
            ST_ENTER:  state_next = ST_IDLE;
            ST_RETURN: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered off the next state so they are valid for the
    // whole cycle spent in that state, with no input-to-output path.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= ST_IDLE;
            cp0_pc_reg      <= '0;
            redirect_pc_reg <= '0;
            cp0_sel_reg     <= '0;
            cp0_wen_reg     <= 1'b0;
            exlset_reg      <= 1'b0;
            exlclr_reg      <= 1'b0;
            pc_redirect_reg <= 1'b0;
            stall_reg       <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cp0_wen_reg     <= (state_next == ST_SAVE);
            cp0_sel_reg     <= (state_next == ST_SAVE) ? SEL_EPC : 5'd0;
            exlset_reg      <= (state_next == ST_SAVE);
            exlclr_reg      <= (state_next == ST_RETURN);
            pc_redirect_reg <= (state_next == ST_ENTER) || (state_next == ST_RETURN);
            stall_reg       <= (state_next != ST_IDLE);
            if (state_reg == ST_IDLE && state_next == ST_SAVE) begin
                cp0_pc_reg <= next_pc;
            end
            if (state_next == ST_ENTER) begin
                redirect_pc_reg <= HANDLER_ADDR;
            end else if (state_next == ST_RETURN) begin
                redirect_pc_reg <= epc;
            end
        end
    end

    assign cp0_pc      = cp0_pc_reg;
    assign cp0_wen     = cp0_wen_reg;
    assign cp0_sel     = cp0_sel_reg;
    assign exlset      = exlset_reg;
    assign exlclr      = exlclr_reg;
    assign pc_redirect = pc_redirect_reg;
    assign redirect_pc = redirect_pc_reg;
    assign stall       = stall_reg;

`ifdef EXC_SEQ_STATS_EN
    exc_stat_cnt #(
        .W(CNT_W)
    ) u_stat_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (1'b0),
        .inc   (state_reg == ST_ENTER),
        .count (int_count)
    );
`else
    assign int_count = '0;
`endif

endmodule

// File: tb/tb_exc_seq.sv
// Randomized bench for exc_seq against a queue-of-expected-cycles reference model.
module tb_exc_seq;

    localparam logic [31:0] HANDLER = 32'h0000_4180;
    localparam int          CW      = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          intreq, instr_done, eret;
    logic [31:0]   next_pc, epc;
    logic [31:0]   cp0_pc, redirect_pc;
    logic          cp0_wen, exlset, exlclr, pc_redirect, stall;
    logic [4:0]    cp0_sel;
    logic [CW-1:0] int_count;

    always #5 clk = ~clk;

    exc_seq #(.HANDLER_ADDR(HANDLER), .CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .intreq      (intreq),
        .instr_done  (instr_done),
        .eret        (eret),
        .next_pc     (next_pc),
        .epc         (epc),
        .cp0_pc      (cp0_pc),
        .cp0_wen     (cp0_wen),
        .cp0_sel     (cp0_sel),
        .exlset      (exlset),
        .exlclr      (exlclr),
        .pc_redirect (pc_redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .int_count   (int_count)
    );

    // One record describes the outputs expected during one busy cycle.
    typedef struct {
        logic        wen;
        logic [4:0]  sel;
        logic        set;
        logic        clr;
        logic        redir;
        logic        stl;
        logic        enter;
        logic [31:0] rpc;
    } rec_t;

    rec_t        q[$];
    rec_t        cur;
    rec_t        idle_rec;
    bit          cur_busy;
    logic [31:0] m_cp0_pc, m_rpc;
    int          m_cnt;
    int          n_cmp = 0;
    int          n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input logic r, input logic id, input logic er,
                              input logic ir, input logic [31:0] np, input logic [31:0] ep);
        if (r) begin
            q.delete();
            cur      = idle_rec;
            cur_busy = 0;
            m_cp0_pc = '0;
            m_rpc    = '0;
            m_cnt    = 0;
            return;
        end
`ifdef EXC_SEQ_STATS_EN
        if (cur_busy && cur.enter && m_cnt < (1 << CW) - 1) m_cnt++;
`endif
        if (!cur_busy && id) begin
            if (er) begin
                q.push_back('{wen:0, sel:0, set:0, clr:1, redir:1, stl:1, enter:0, rpc:ep});
                $display("txn ERET    target=%h", ep);
            end else if (ir) begin
                m_cp0_pc = np;
                q.push_back('{wen:1, sel:14, set:1, clr:0, redir:0, stl:1, enter:0, rpc:0});
                q.push_back('{wen:0, sel:0, set:0, clr:0, redir:1, stl:1, enter:1, rpc:HANDLER});
                $display("txn INTR    epc=%h", np);
            end
        end
        if (q.size() > 0) begin
            cur      = q.pop_front();
            cur_busy = 1;
            if (cur.redir) m_rpc = cur.rpc;
        end else begin
            cur      = idle_rec;
            cur_busy = 0;
        end
    endtask

    task automatic step(input logic r, input logic id, input logic er,
                        input logic ir, input logic [31:0] np, input logic [31:0] ep);
        @(negedge clk);
        rst = r; instr_done = id; eret = er; intreq = ir; next_pc = np; epc = ep;
        @(posedge clk);
        model_edge(r, id, er, ir, np, ep);
        #1;
        check("cp0_wen",     {31'd0, cp0_wen},     {31'd0, cur.wen});
        check("cp0_sel",     {27'd0, cp0_sel},     {27'd0, cur.sel});
        check("exlset",      {31'd0, exlset},      {31'd0, cur.set});
        check("exlclr",      {31'd0, exlclr},      {31'd0, cur.clr});
        check("pc_redirect", {31'd0, pc_redirect}, {31'd0, cur.redir});
        check("stall",       {31'd0, stall},       {31'd0, cur.stl});
        check("cp0_pc",      cp0_pc,               m_cp0_pc);
        check("redirect_pc", redirect_pc,          m_rpc);
        check("int_count",   {{(32-CW){1'b0}}, int_count}, m_cnt);
    endtask

    initial begin
        logic        r, id, er, ir;
        logic [31:0] np, ep;
        idle_rec = '{wen:0, sel:0, set:0, clr:0, redir:0, stl:0, enter:0, rpc:0};
        cur = idle_rec; cur_busy = 0;
        m_cp0_pc = '0; m_rpc = '0; m_cnt = 0;
        rst = 1'b1; instr_done = 0; eret = 0; intreq = 0; next_pc = '0; epc = '0;

        // Reset, then instr_done alone
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(1, 1, 1, 1, 32'h0, 32'h0);
        repeat (3) step(0, 1, 0, 0, 32'h0000_1000, 32'h0);
        // Interrupt entry
        step(0, 1, 0, 1, 32'h0000_3010, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        // ERET exit
        step(0, 1, 1, 0, 32'h0, 32'h0000_3010);
        step(0, 0, 0, 0, 32'h0, 32'h0000_3010);
        step(0, 0, 0, 0, 32'h0, 32'h0000_3010);
        // ERET beats intreq; intreq taken two cycles later
        step(0, 1, 1, 1, 32'h0000_2000, 32'h0000_5550);
        step(0, 0, 0, 1, 32'h0000_2000, 32'h0000_5550);
        step(0, 1, 0, 1, 32'h0000_2040, 32'h0000_5550);
        step(0, 0, 0, 1, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        // Reset during SAVE, then a clean entry
        step(0, 1, 0, 1, 32'h0000_6000, 32'h0);
        step(1, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 1, 0, 1, 32'h0000_6004, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 0, 32'h0, 32'h0);
        // Five entries for the counter saturation case
        step(1, 0, 0, 0, 32'h0, 32'h0);
        for (int k = 0; k < 5; k++) begin
            step(0, 1, 0, 1, 32'h0000_7000 + 32'(k * 4), 32'h0);
            step(0, 0, 0, 0, 32'h0, 32'h0);
            step(0, 0, 0, 0, 32'h0, 32'h0);
            step(0, 0, 0, 0, 32'h0, 32'h0);
        end

        // Random traffic; epc only moves while the model is idle
        ep = 32'h0;
        for (int i = 0; i < 2000; i++) begin
            r  = ($urandom_range(0, 63) == 0);
            id = $urandom_range(0, 1) == 1;
            er = $urandom_range(0, 3) == 0;
            ir = $urandom_range(0, 1) == 1;
            np = {$urandom, 2'b00} & 32'hFFFF_FFFC;
            if (!cur_busy) ep = $urandom & 32'hFFFF_FFFC;
            step(r, id, er, ir, np, ep);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
